// File: rtl/egress_ovp_sched.sv
// egress_ovp_sched: classifies fabric blocks into three OVP queues and round-robins them onto the PHY IPG slot interface
module egress_ovp_sched #(
  parameter int DATA_WIDTH = 64,
  parameter int QUEUE_DEPTH = 8,
  parameter logic [7:0] RREQ_TYPE = 8'h1a,
  parameter logic [7:0] WREQ_TYPE = 8'h1e,
  parameter logic [7:0] RRESP_TYPE = 8'h2d,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH-1:0]         tx_ipg_data,
  output logic                          tx_ipg_en,
  input  logic                          tx_ipg_ready,
  output logic [$clog2(QUEUE_DEPTH):0]  q_level_rreq,
  output logic [$clog2(QUEUE_DEPTH):0]  q_level_wreq,
  output logic [$clog2(QUEUE_DEPTH):0]  q_level_rresp,
  output logic [CNT_WIDTH-1:0]          drop_cnt
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int LW = AW + 1;
  logic [2:0][LW-1:0] lvl;
  logic [DATA_WIDTH-1:0] head [3];
  logic [2:0] sel, full, ne, push, pop;
  logic [1:0] rr, i1, g;
  logic load, drop;
  assign sel = {in_data[7:0] == RRESP_TYPE, in_data[7:0] == WREQ_TYPE, in_data[7:0] == RREQ_TYPE};
  assign in_ready = sel[0] ? !full[0] : sel[1] ? !full[1] : sel[2] ? !full[2] : 1'b1;
  assign drop = in_valid && !(|sel);
  assign q_level_rreq = lvl[0];
  assign q_level_wreq = lvl[1];
  assign q_level_rresp = lvl[2];
  for (genvar q = 0; q < 3; q++) begin : g_q
    logic [LW-1:0] wp, rp;
    logic [DATA_WIDTH-1:0] mem [QUEUE_DEPTH];
    assign lvl[q] = wp - rp;
    assign full[q] = lvl[q] == LW'(QUEUE_DEPTH);
    assign ne[q] = lvl[q] != '0;
    assign push[q] = in_valid && in_ready && sel[q];
    assign pop[q] = load && g == 2'(q);
    assign head[q] = mem[rp[AW-1:0]];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        wp <= '0;
        rp <= '0;
      end else begin
        wp <= wp + LW'(push[q]);
        rp <= rp + LW'(pop[q]);
      end
    always_ff @(posedge clk)
      if (push[q]) mem[wp[AW-1:0]] <= in_data;
  end
  // rr names the queue with highest priority for the next grant
  always_comb begin
    i1 = rr == 2'd2 ? 2'd0 : rr + 2'd1;
    g = ne[rr] ? rr : ne[i1] ? i1 : (i1 == 2'd2 ? 2'd0 : i1 + 2'd1);
    load = (!tx_ipg_en || tx_ipg_ready) && |ne;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr <= 2'd0;
      tx_ipg_en <= 1'b0;
      tx_ipg_data <= '0;
      drop_cnt <= '0;
    end else begin
      if (load) begin
        tx_ipg_data <= head[g];
        tx_ipg_en <= 1'b1;
        rr <= g == 2'd2 ? 2'd0 : g + 2'd1;
      end else if (tx_ipg_ready) tx_ipg_en <= 1'b0;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
endmodule

// File: tb/tb_egress_ovp_sched.sv
// tb_egress_ovp_sched: directed checks of classification, arbitration, backpressure, reset and drop saturation
module tb_egress_ovp_sched;
  logic clk = 0, rst = 1;
  logic [63:0] in_data = '0, tx_ipg_data;
  logic in_valid = 0, in_ready, tx_ipg_en, tx_ipg_ready = 0;
  logic [3:0] q_level_rreq, q_level_wreq, q_level_rresp;
  logic [15:0] drop_cnt;
  int n_chk = 0, n_fail = 0;
  logic [63:0] exp_q [$];
  egress_ovp_sched dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_ipg_data(tx_ipg_data), .tx_ipg_en(tx_ipg_en), .tx_ipg_ready(tx_ipg_ready),
    .q_level_rreq(q_level_rreq), .q_level_wreq(q_level_wreq), .q_level_rresp(q_level_rresp),
    .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [63:0] d);
    in_data = d;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic levels(input string tag, input logic [3:0] r, input logic [3:0] w, input logic [3:0] p);
    check({tag, "_lvl_rreq"}, q_level_rreq, r);
    check({tag, "_lvl_wreq"}, q_level_wreq, w);
    check({tag, "_lvl_rresp"}, q_level_rresp, p);
  endtask
  initial begin
    #12;
    check("rst_en", tx_ipg_en, 0);
    check("rst_data", tx_ipg_data, 0);
    check("rst_drop", drop_cnt, 0);
    levels("rst", 0, 0, 0);
    @(negedge clk);
    rst = 0;
    tx_ipg_ready = 1;
    @(negedge clk);
    push(64'h123456781234561a);
    check("lat_en_k", tx_ipg_en, 0);
    check("lat_lvl_k", q_level_rreq, 1);
    @(negedge clk);
    check("lat_en_k1", tx_ipg_en, 1);
    check("lat_data_k1", tx_ipg_data, 64'h123456781234561a);
    check("lat_lvl_k1", q_level_rreq, 0);
    @(negedge clk);
    check("lat_en_off", tx_ipg_en, 0);
    check("lat_data_hold", tx_ipg_data, 64'h123456781234561a);
    tx_ipg_ready = 0;
    push(64'hA0_0000000000001a);
    push(64'hA1_0000000000001a);
    push(64'hB0_0000000000001e);
    push(64'hB1_0000000000001e);
    push(64'hC0_0000000000002d);
    push(64'hC1_0000000000002d);
    levels("rr", 1, 2, 2);
    tx_ipg_ready = 1;
    exp_q = '{64'hA0_0000000000001a, 64'hB0_0000000000001e, 64'hC0_0000000000002d,
              64'hA1_0000000000001a, 64'hB1_0000000000001e, 64'hC1_0000000000002d};
    foreach (exp_q[i]) begin
      check($sformatf("rr_en%0d", i), tx_ipg_en, 1);
      check($sformatf("rr_data%0d", i), tx_ipg_data, exp_q[i]);
      @(negedge clk);
    end
    check("rr_idle", tx_ipg_en, 0);
    tx_ipg_ready = 0;
    for (int i = 0; i < 9; i++) begin
      in_data = {8'(i), 48'h0, 8'h1a};
      #1 check($sformatf("fill_rdy%0d", i), in_ready, 1);
      push({8'(i), 48'h0, 8'h1a});
    end
    check("full_lvl", q_level_rreq, 8);
    in_data = 64'h1a;
    #1 check("full_rdy_rreq", in_ready, 0);
    in_data = 64'h1e;
    #1 check("full_rdy_wreq", in_ready, 1);
    in_data = 64'h1a;
    tx_ipg_ready = 1;
    #1 check("full_nobypass", in_ready, 0);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("drain%0d", i), tx_ipg_data, {8'(i), 48'h0, 8'h1a});
      @(negedge clk);
    end
    check("drain_idle", tx_ipg_en, 0);
    check("drain_lvl", q_level_rreq, 0);
    in_data = 64'h666600000000007f;
    #1 check("unk_rdy", in_ready, 1);
    repeat (3) push(64'h666600000000007f);
    check("unk_drop", drop_cnt, 3);
    @(negedge clk);
    check("unk_en", tx_ipg_en, 0);
    levels("unk", 0, 0, 0);
    tx_ipg_ready = 0;
    push(64'hBEEF00000000001e);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_en%0d", i), tx_ipg_en, 1);
      check($sformatf("bp_data%0d", i), tx_ipg_data, 64'hBEEF00000000001e);
      @(negedge clk);
    end
    push(64'hCAFE00000000002d);
    levels("bp", 0, 0, 1);
    check("bp_data_after", tx_ipg_data, 64'hBEEF00000000001e);
    repeat (3) push(64'h5555_00000000001a);
    levels("pre_rst", 3, 0, 1);
    #1 rst = 1;
    #1;
    check("arst_en", tx_ipg_en, 0);
    check("arst_data", tx_ipg_data, 0);
    check("arst_drop", drop_cnt, 0);
    levels("arst", 0, 0, 0);
    @(negedge clk);
    rst = 0;
    push(64'h7777_00000000002d);
    check("post_rst_en_k", tx_ipg_en, 0);
    @(negedge clk);
    check("post_rst_en", tx_ipg_en, 1);
    check("post_rst_data", tx_ipg_data, 64'h7777_00000000002d);
    in_data = 64'h55;
    in_valid = 1;
    repeat (65540) @(negedge clk);
    in_valid = 0;
    check("drop_sat", drop_cnt, 16'hffff);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
